// File: rtl/tt_pin_link_responder.sv
// Purpose : byte-wide 4-phase req/ack register-file responder on the Tiny Tapeout pins.
// Latency : ack, memory write and uo_out update all land on the first edge req is sampled high.
// Backpress: fabric paces every byte with req/ack; ena=0 freezes all state, abort ends the frame.
// Optional: define TT_LINK_PARITY_EN for even parity on ui_in (uio_in[3]) and on uo_out (uio_out[7]).
module tt_pin_link_responder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NREG = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CMD_HS    = 2'd1;
    localparam logic [1:0] ST_DATA_WAIT = 2'd2;
    localparam logic [1:0] ST_DATA_HS   = 2'd3;

    // Control pins from the fabric.
    logic req;
    logic last_in;
    logic abort;
    assign req     = uio_in[0];
    assign last_in = uio_in[1];
    assign abort   = uio_in[2];

    // Parity of the presented byte; a mismatch flags err but never stalls the handshake.
    logic par_bad;
`ifdef TT_LINK_PARITY_EN
    assign par_bad = ^{ui_in, uio_in[3]};
`else
    assign par_bad = 1'b0;
`endif

    // Upper command address bits and bits [7:4] of uio_in carry nothing for this block.
    logic unused_inputs;
    assign unused_inputs = ^{ui_in, uio_in};

    // Registered state.
    logic [1:0]            state;
    logic [DEPTH_LOG2-1:0] addr;
    logic                  we_q;
    logic                  inc_q;
    logic                  last_q;
    logic                  ack_q;
    logic                  err_q;
    logic [7:0]            rd_q;
    logic [7:0]            mem [NREG];

    // Next-state values.
    logic [1:0]            state_nxt;
    logic [DEPTH_LOG2-1:0] addr_nxt;
    logic                  we_nxt;
    logic                  inc_nxt;
    logic                  last_nxt;
    logic                  ack_nxt;
    logic                  err_nxt;
    logic                  rd_load;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  mem_we;

    // Command decode: a command with bad parity is downgraded to a read so it cannot corrupt memory.
    logic                  cmd_we;
    logic                  cmd_inc;
    logic [DEPTH_LOG2-1:0] cmd_addr;
    assign cmd_we   = ui_in[7] & ~par_bad;
    assign cmd_inc  = ui_in[6];
    assign cmd_addr = ui_in[DEPTH_LOG2-1:0];

    // Handshake FSM next-state logic; abort outranks every handshake step.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        we_nxt    = we_q;
        inc_nxt   = inc_q;
        last_nxt  = last_q;
        ack_nxt   = ack_q;
        err_nxt   = err_q;
        rd_load   = 1'b0;
        rd_addr   = addr;
        mem_we    = 1'b0;

        if (ena) begin
            if (abort) begin
                // Abort in IDLE leaves everything untouched and accepts no command.
                if (state != ST_IDLE) begin
                    state_nxt = ST_IDLE;
                    ack_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            we_nxt    = cmd_we;
                            inc_nxt   = cmd_inc;
                            last_nxt  = last_in;
                            err_nxt   = par_bad;
                            ack_nxt   = 1'b1;
                            state_nxt = ST_CMD_HS;
                            if (cmd_we) begin
                                addr_nxt = cmd_addr;
                            end else begin
                                // Reads fetch the first byte on the command itself.
                                rd_load  = 1'b1;
                                rd_addr  = cmd_addr;
                                addr_nxt = cmd_addr + DEPTH_LOG2'(cmd_inc);
                            end
                        end
                    end
                    ST_CMD_HS, ST_DATA_HS: begin
                        if (!req) begin
                            ack_nxt   = 1'b0;
                            state_nxt = last_q ? ST_IDLE : ST_DATA_WAIT;
                        end
                    end
                    ST_DATA_WAIT: begin
                        if (req) begin
                            last_nxt  = last_in;
                            ack_nxt   = 1'b1;
                            addr_nxt  = addr + DEPTH_LOG2'(inc_q);
                            state_nxt = ST_DATA_HS;
                            if (par_bad) begin
                                err_nxt = 1'b1;
                            end
                            if (we_q) begin
                                mem_we = ~par_bad;
                            end else begin
                                rd_load = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        ack_nxt   = 1'b0;
                    end
                endcase
            end
        end
    end

    // FSM and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr   <= '0;
            we_q   <= 1'b0;
            inc_q  <= 1'b0;
            last_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            we_q   <= we_nxt;
            inc_q  <= inc_nxt;
            last_q <= last_nxt;
            ack_q  <= ack_nxt;
            err_q  <= err_nxt;
        end
    end

    // Register file; cleared on reset so a mid-frame reset leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr] <= ui_in;
        end
    end

    // Read data register; holds between reads, writes never touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_load) begin
            rd_q <= mem[rd_addr];
        end
    end

`ifdef TT_LINK_PARITY_EN
    logic par_q;

    // Outgoing parity tracks uo_out on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (rd_load) begin
            par_q <= ^mem[rd_addr];
        end
    end
`else
    logic par_q;
    assign par_q = 1'b0;
`endif

    logic busy;
    assign busy = (state != ST_IDLE);

    assign uo_out  = rd_q;
    assign uio_out = {par_q, err_q, busy, ack_q, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_pin_link_responder.sv
// Purpose : self-checking bench for tt_pin_link_responder (table of frames plus corner sequences).
// Latency : expects ack one edge after req is sampled, and ack drop one edge after req falls.
// Backpress: every wait on the DUT is bounded; an expired bound counts as a failure.
module tb_tt_pin_link_responder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] sb_q [$];

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
        logic       pbad;
        logic       chk;
        logic [7:0] exp_uo;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    tt_pin_link_responder #(.DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] v);
`ifdef TT_LINK_PARITY_EN
        return ^v;
`else
        return 1'b0 & v[0];
`endif
    endfunction

    // One full req/ack byte phase, starting and ending on a falling edge.
    task automatic phase(input logic [7:0] dat, input logic last, input logic pbad,
                         input logic chk, input logic [7:0] exp_uo, input logic exp_err,
                         input logic exp_busy, input string nm);
        int n;
        logic [7:0] e;
        ui_in  = dat;
        uio_in = {4'b0000, (^dat) ^ pbad, 1'b0, last, 1'b1};
        if (chk) sb_q.push_back(exp_uo);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uio_out[4] && n < 8);
        check({nm, "_ack_rise_cycles"}, n, 1);
        if (chk) begin
            if (sb_q.size() == 0) begin
                check({nm, "_scoreboard_empty"}, 1, 0);
            end else begin
                e = sb_q.pop_front();
                check({nm, "_uo_out"}, uo_out, e);
                check({nm, "_par_out"}, uio_out[7], exp_par(e));
            end
        end
        check({nm, "_err"}, uio_out[6], exp_err);
        uio_in[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uio_out[4] && n < 8);
        check({nm, "_ack_fall_cycles"}, n, 1);
        check({nm, "_busy"}, uio_out[5], exp_busy);
    endtask

    initial begin
        // dat, last, pbad, chk, exp_uo, exp_err, exp_busy
        vecs[0]  = '{8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; // write cmd addr 3, inc
        vecs[1]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; // mem[3]=A5
        vecs[2]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}; // mem[4]=5A, end
        vecs[3]  = '{8'h43, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1}; // read cmd addr 3
        vecs[4]  = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}; // read mem[4]
        vecs[5]  = '{8'hCF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; // write cmd addr 15
        vecs[6]  = '{8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}; // mem[15]=11
        vecs[7]  = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}; // mem[0]=22 (wrap)
        vecs[8]  = '{8'h4F, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1}; // read addr 15
        vecs[9]  = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0}; // wrapped read mem[0]
        vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0}; // read addr 0, no inc
        vecs[11] = '{8'h85, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0}; // zero-length write, uo held
        vecs[12] = '{8'h05, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}; // mem[5] untouched
        vecs[13] = '{8'h03, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1}; // read addr 3, no inc
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1}; // address stays 3
        vecs[15] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0}; // data byte ignored on read
        vecs[16] = '{8'h04, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}; // mem[4] still 5A

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        check("oe_during_reset", uio_oe, 8'hF0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);

        // Every register reads back zero after reset.
        for (int a = 0; a < 16; a++) begin
            phase(8'(a), 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, $sformatf("rst_rd%0d", a));
        end

        for (int i = 0; i < NVEC; i++) begin
            phase(vecs[i].dat, vecs[i].last, vecs[i].pbad, vecs[i].chk, vecs[i].exp_uo,
                  vecs[i].exp_err, vecs[i].exp_busy, $sformatf("vec%0d", i));
        end

        // Abort in DATA_WAIT of a write burst.
        phase(8'hC8, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "abt_cmd");
        ui_in  = 8'h77;
        uio_in = {4'b0000, ^8'h77, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        check("abt_ack", uio_out[4], 1'b0);
        check("abt_busy", uio_out[5], 1'b0);
        check("abt_err", uio_out[6], 1'b1);
        uio_in = 8'h00;
        @(negedge clk);
        check("abt_err_held", uio_out[6], 1'b1);
        phase(8'h08, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "abt_rd");

        // ena low holds off a pending request.
        ena    = 1'b0;
        ui_in  = 8'h03;
        uio_in = {4'b0000, ^8'h03, 1'b0, 1'b1, 1'b1};
        repeat (5) @(negedge clk);
        check("ena_ack_held", uio_out[4], 1'b0);
        check("ena_busy_held", uio_out[5], 1'b0);
        ena = 1'b1;
        sb_q.push_back(8'hA5);
        @(negedge clk);
        check("ena_ack_rise", uio_out[4], 1'b1);
        check("ena_uo_out", uo_out, sb_q.pop_front());
        uio_in[0] = 1'b0;
        @(negedge clk);
        check("ena_ack_fall", uio_out[4], 1'b0);
        check("ena_busy_end", uio_out[5], 1'b0);

`ifdef TT_LINK_PARITY_EN
        // Bad parity on a write data byte: err set, memory unchanged.
        phase(8'hC6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "par_cmd");
        phase(8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "par_bad_dat");
        phase(8'h06, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "par_rd");
`endif

        // Reset in the middle of a frame clears memory and state.
        ui_in  = 8'hC3;
        uio_in = {4'b0000, ^8'hC3, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        check("mid_ack", uio_out[4], 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_uio_out", uio_out, 8'h00);
        check("mid_rst_uo_out", uo_out, 8'h00);
        check("mid_rst_oe", uio_oe, 8'hF0);
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        phase(8'h03, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "mid_rd3");
        phase(8'h0F, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "mid_rd15");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
